div_arbiter: RTL and testbench
==============================

Name: div_arbiter

Overview:
- Shares one sequential signed 8-bit divider (clk/reset/start/a/b → quotient/done) between two independent requesters inside the ALU.
- Arbitrates round-robin and latches the winner's operands.
- Holds the divider inputs stable for the whole operation, waits for the divider's done pulse, and returns the quotient to the owning requester with a one-cycle valid.
- One division in flight at a time.

Parameters:
- DATA_W, 8, operand width (signed dividend and divisor)
- RES_W, 16, result width; must equal 2*DATA_W

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- req0  in  1  requester 0 request; level, held with a0/b0 until ack0
- a0  in  DATA_W  requester 0 signed dividend
- b0  in  DATA_W  requester 0 signed divisor
- ack0  out  1  one-cycle pulse: request 0 accepted and operands captured
- res_valid0  out  1  one-cycle pulse: res0/res_dz0 valid
- res0  out  RES_W  signed quotient for requester 0; holds until next res_valid0
- res_dz0  out  1  divide-by-zero flag (see Optional Feature)
- req1, a1, b1, ack1, res_valid1, res1, res_dz1: same as above, for requester 1
- div_start  out  1  start to divider
- div_a  out  DATA_W  dividend to divider
- div_b  out  DATA_W  divisor to divider
- div_quotient  in  RES_W  divider result
- div_done  in  1  divider done pulse (one cycle)

Behaviour:
- Reset values, all outputs 0: ack*, res_valid*, res*, res_dz*, div_start, div_a, div_b. Reset also sets state=IDLE, owner=0, last_grant=1, so req0 wins the first tie.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high at the clock edge: pick the winner.
  - Winner = the only requester asserting; on a tie, the requester not equal to last_grant.
  - Latch the winner's a/b into div_a/div_b and set owner.
  - Set last_grant=owner, pulse ack<owner> for the following cycle, go to ISSUE.
- ISSUE: div_start=1 for exactly this one cycle; go to WAIT.
- WAIT:
  - div_start=0; hold div_a/div_b.
  - On div_done=1: capture div_quotient into res<owner>, go to RESP.
  - div_done is ignored in every state except WAIT.
- RESP:
  - res_valid<owner>=1 for this one cycle; go to IDLE.
  - The non-owner's res/res_valid are untouched.
- div_a/div_b stay constant from the ISSUE cycle until the next grant. The divider re-reads b during its own operation, so this hold is mandatory.
- Requester contract: hold req and operands until ack is seen, then drop req on the next cycle. A req still high when the FSM returns to IDLE is treated as a new request.
- Arbitration examples:
  - A requester asserting req while the other's job is in flight waits, with no ack, until IDLE.
  - Back-to-back: if both requesters keep requesting, grants alternate 0,1,0,1.
- Latency: ack arrives 1 cycle after req is sampled in IDLE; res_valid arrives 2 cycles after div_done (WAIT capture, then RESP). End-to-end is at most 16 cycles for DATA_W=8.
- Reset mid-operation: FSM returns to IDLE the next cycle; the in-flight result is discarded; no res_valid or ack is issued. The divider shares the same reset.
- Width: quotients are passed through unmodified (sign handling is the divider's job).

Optional Feature:
- Macro: DIV_ZERO_BYPASS_EN.
- With the macro:
  - A granted request with b==0 skips ISSUE/WAIT: IDLE → RESP directly.
  - res=0, res_dz=1; ack still pulses; res_valid follows ack on the next cycle.
  - div_start is never asserted for that request; div_a/div_b are still latched.
- Without the macro:
  - b==0 goes through the divider normally; res is whatever the divider returns (0).
  - res_dz ports are tied 0; the port list is unchanged.

Decomposition:
- Package div_arb_pkg holds:
  - localparams for the FSM state encodings (IDLE/ISSUE/WAIT/RESP, 2 bits)
  - DATA_W/RES_W defaults
  - requester ID constants REQ0=0, REQ1=1
- Sub-module rr_grant2: combinational two-way round-robin pick from (req0, req1, last_grant) → (grant_valid, grant_id). It is shared by any future two-client ALU arbiter.

Test Plan:
- req0, a0=100, b0=7 → ack0 one cycle later; div_start single pulse with div_a=100, div_b=7; res_valid0 with res0=14 (0x000E); ack1/res_valid1 never assert.
- req1, a1=-100, b1=7 → res1=0xFFF2 (-14); div_a/div_b stable from ISSUE until div_done.
- req0 (20,3) and req1 (-9,2) asserted in the same cycle after reset → req0 served first with res0=6; then req1 with res1=0xFFFC (-4). Repeat a tie → req1 first.
- Spurious div_done pulse while in IDLE or ISSUE → no state change, no res_valid.
- reset asserted in WAIT (mid-divide) → next cycle all outputs 0; no res_valid; a new req0 (9,3) afterwards yields res0=3.
- b0=0, a0=50:
  - with DIV_ZERO_BYPASS_EN → res0=0, res_dz0=1, no div_start, res_valid0 one cycle after ack0.
  - without the macro → divider is run, res0=0, res_dz0=0.

Source files
------------

// File: rtl/div_arb_pkg.sv
// Shared types and constants for the two-requester divider arbiter.
package div_arb_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned RES_W_DEF  = 2 * DATA_W_DEF;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    WAIT  = ST_WAIT,
    RESP  = ST_RESP
  } arb_state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Operand pair as presented to the shared divider.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] a;
    logic [DATA_W_DEF-1:0] b;
  } div_op_t;

endpackage

// File: rtl/div_arbiter_if.sv
// Requester and divider-side signal bundle for div_arbiter.
interface div_arbiter_if #(
  parameter int unsigned DATA_W = div_arb_pkg::DATA_W_DEF,
  parameter int unsigned RES_W  = div_arb_pkg::RES_W_DEF
) ();

  logic              req0;
  logic [DATA_W-1:0] a0;
  logic [DATA_W-1:0] b0;
  logic              ack0;
  logic              res_valid0;
  logic [RES_W-1:0]  res0;
  logic              res_dz0;

  logic              req1;
  logic [DATA_W-1:0] a1;
  logic [DATA_W-1:0] b1;
  logic              ack1;
  logic              res_valid1;
  logic [RES_W-1:0]  res1;
  logic              res_dz1;

  logic              div_start;
  logic [DATA_W-1:0] div_a;
  logic [DATA_W-1:0] div_b;
  logic [RES_W-1:0]  div_quotient;
  logic              div_done;

  // Arbiter side.
  modport slave (
    input  req0, a0, b0, req1, a1, b1, div_quotient, div_done,
    output ack0, res_valid0, res0, res_dz0,
    output ack1, res_valid1, res1, res_dz1,
    output div_start, div_a, div_b
  );

  // Requesters plus divider side.
  modport master (
    output req0, a0, b0, req1, a1, b1, div_quotient, div_done,
    input  ack0, res_valid0, res0, res_dz0,
    input  ack1, res_valid1, res1, res_dz1,
    input  div_start, div_a, div_b
  );

endinterface

// File: rtl/rr_grant2.sv
// Combinational two-way round-robin pick; on a tie the client that did not win last time is chosen.
module rr_grant2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid_c,
  output logic grant_id_c
);

  assign grant_valid_c = req0 | req1;
  assign grant_id_c    = (req0 & req1) ? ~last_grant : req1;

endmodule

// File: rtl/div_arbiter.sv
// Round-robin sharing of one sequential signed divider between two requesters.
// Optional build macro DIV_ZERO_BYPASS_EN answers divide-by-zero requests without using the divider.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned RES_W  = RES_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  div_arbiter_if.slave bus
);

  if (RES_W != 2 * DATA_W) begin : g_bad_width
    $error("div_arbiter: RES_W must equal 2*DATA_W");
  end

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic              rv0_q, rv0_d, rv1_q, rv1_d;
  logic [RES_W-1:0]  res0_q, res0_d, res1_q, res1_d;
  logic              dz0_q, dz0_d, dz1_q, dz1_d;
  logic              start_q, start_d;
  logic [DATA_W-1:0] div_a_q, div_a_d, div_b_q, div_b_d;

  logic              grant_valid_c;
  logic              grant_id_c;
  logic [DATA_W-1:0] sel_a_c;
  logic [DATA_W-1:0] sel_b_c;

  rr_grant2 u_rr_grant2 (
    .req0          (bus.req0),
    .req1          (bus.req1),
    .last_grant    (last_grant_q),
    .grant_valid_c (grant_valid_c),
    .grant_id_c    (grant_id_c)
  );

  assign sel_a_c = (grant_id_c == REQ1) ? bus.a1 : bus.a0;
  assign sel_b_c = (grant_id_c == REQ1) ? bus.b1 : bus.b0;

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= REQ0;
      last_grant_q <= REQ1;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rv0_q        <= 1'b0;
      rv1_q        <= 1'b0;
      res0_q       <= '0;
      res1_q       <= '0;
      dz0_q        <= 1'b0;
      dz1_q        <= 1'b0;
      start_q      <= 1'b0;
      div_a_q      <= '0;
      div_b_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rv0_q        <= rv0_d;
      rv1_q        <= rv1_d;
      res0_q       <= res0_d;
      res1_q       <= res1_d;
      dz0_q        <= dz0_d;
      dz1_q        <= dz1_d;
      start_q      <= start_d;
      div_a_q      <= div_a_d;
      div_b_q      <= div_b_d;
    end
  end

  // Next state and next output values; every output register is set up one cycle ahead.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rv0_d        = 1'b0;
    rv1_d        = 1'b0;
    res0_d       = res0_q;
    res1_d       = res1_q;
    dz0_d        = dz0_q;
    dz1_d        = dz1_q;
    start_d      = 1'b0;
    div_a_d      = div_a_q;
    div_b_d      = div_b_q;

    unique case (state_q)
      IDLE: begin
        if (grant_valid_c) begin
          owner_d      = grant_id_c;
          last_grant_d = grant_id_c;
          div_a_d      = sel_a_c;
          div_b_d      = sel_b_c;
          ack0_d       = (grant_id_c == REQ0);
          ack1_d       = (grant_id_c == REQ1);
`ifdef DIV_ZERO_BYPASS_EN
          if (sel_b_c == '0) begin
            state_d = RESP;
            if (grant_id_c == REQ0) begin
              res0_d = '0;
              dz0_d  = 1'b1;
            end else begin
              res1_d = '0;
              dz1_d  = 1'b1;
            end
          end else begin
            state_d = ISSUE;
            start_d = 1'b1;
          end
`else
          state_d = ISSUE;
          start_d = 1'b1;
`endif
        end
      end

      ISSUE: begin
        state_d = WAIT;
      end

      WAIT: begin
        if (bus.div_done) begin
          state_d = RESP;
          if (owner_q == REQ0) begin
            res0_d = bus.div_quotient;
            dz0_d  = 1'b0;
          end else begin
            res1_d = bus.div_quotient;
            dz1_d  = 1'b0;
          end
        end
      end

      RESP: begin
        rv0_d   = (owner_q == REQ0);
        rv1_d   = (owner_q == REQ1);
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ack0       = ack0_q;
  assign bus.ack1       = ack1_q;
  assign bus.res_valid0 = rv0_q;
  assign bus.res_valid1 = rv1_q;
  assign bus.res0       = res0_q;
  assign bus.res1       = res1_q;
  assign bus.res_dz0    = dz0_q;
  assign bus.res_dz1    = dz1_q;
  assign bus.div_start  = start_q;
  assign bus.div_a      = div_a_q;
  assign bus.div_b      = div_b_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Directed scoreboard bench for div_arbiter with a behavioural sequential divider.
module tb_div_arbiter;
  import div_arb_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned RW = 16;

  typedef struct packed {
    logic [RW-1:0] res;
    logic          dz;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  div_arbiter_if #(.DATA_W(DW), .RES_W(RW)) bus ();

  div_arbiter #(.DATA_W(DW), .RES_W(RW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  exp_t q0[$];
  exp_t q1[$];
  int   grant_log[$];
  int   n_start = 0;
  int   ack_cyc[2];
  int   rv_cyc[2];
  int   done_cyc = 0;
  int   drive_cyc = 0;

  logic          mdl_done = 1'b0;
  logic [RW-1:0] mdl_q = '0;
  logic          spur_done = 1'b0;
  logic          busy = 1'b0;
  int            cnt = 0;
  logic [DW-1:0] la = '0;
  logic [DW-1:0] lb = '0;

  assign bus.div_done     = mdl_done | spur_done;
  assign bus.div_quotient = spur_done ? 16'h5555 : mdl_q;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural divider: result three cycles after start, operands must stay put meanwhile.
  always @(negedge clk) begin
    if (reset) begin
      busy     = 1'b0;
      mdl_done = 1'b0;
    end else if (mdl_done) begin
      mdl_done = 1'b0;
      busy     = 1'b0;
    end else if (busy) begin
      chk("hold_div_a", 64'(bus.div_a), 64'(la));
      chk("hold_div_b", 64'(bus.div_b), 64'(lb));
      chk("start_single_pulse", 64'(bus.div_start), 64'd0);
      if (cnt == 0) begin
        int qa;
        int qb;
        qa = $signed(la);
        qb = $signed(lb);
        mdl_q    = (qb == 0) ? '0 : RW'(qa / qb);
        mdl_done = 1'b1;
        done_cyc = cyc;
      end else begin
        cnt--;
      end
    end else if (bus.div_start) begin
      busy = 1'b1;
      la   = bus.div_a;
      lb   = bus.div_b;
      cnt  = 2;
    end
  end

  // Output monitor and scoreboard check.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.div_start) n_start++;
      if (bus.ack0) begin grant_log.push_back(0); ack_cyc[0] = cyc; end
      if (bus.ack1) begin grant_log.push_back(1); ack_cyc[1] = cyc; end
      if (bus.res_valid0) begin
        rv_cyc[0] = cyc;
        if (q0.size() == 0) chk("res_valid0_unexpected", 64'd1, 64'd0);
        else begin
          exp_t e;
          e = q0.pop_front();
          chk("res0", 64'(bus.res0), 64'(e.res));
          chk("res_dz0", 64'(bus.res_dz0), 64'(e.dz));
        end
      end
      if (bus.res_valid1) begin
        rv_cyc[1] = cyc;
        if (q1.size() == 0) chk("res_valid1_unexpected", 64'd1, 64'd0);
        else begin
          exp_t e;
          e = q1.pop_front();
          chk("res1", 64'(bus.res1), 64'(e.res));
          chk("res_dz1", 64'(bus.res_dz1), 64'(e.dz));
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {9'd0, bus.ack0, bus.ack1, bus.res_valid0, bus.res_valid1, bus.res0, bus.res1,
              bus.res_dz0, bus.res_dz1, bus.div_start, bus.div_a, bus.div_b}, 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic serve(input string tag,
                       input logic r0, input logic [DW-1:0] xa0, input logic [DW-1:0] xb0,
                       input logic [RW-1:0] e0, input logic z0,
                       input logic r1, input logic [DW-1:0] xa1, input logic [DW-1:0] xb1,
                       input logic [RW-1:0] e1, input logic z1);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    if (r0) begin e.res = e0; e.dz = z0; q0.push_back(e); end
    if (r1) begin e.res = e1; e.dz = z1; q1.push_back(e); end
    bus.a0 = xa0; bus.b0 = xb0; bus.req0 = r0;
    bus.a1 = xa1; bus.b1 = xb1; bus.req1 = r1;
    drive_cyc = cyc;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (bus.ack0) bus.req0 = 1'b0;
      if (bus.ack1) bus.req1 = 1'b0;
      if (!bus.req0 && !bus.req1 && q0.size() == 0 && q1.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_complete"}, 64'(ok), 64'd1);
    tick(2);
  endtask

  task automatic chk_grants(input string tag, input int first, input int second);
    chk({tag, "_grant_count"}, 64'(grant_log.size()), (second < 0) ? 64'd1 : 64'd2);
    if (grant_log.size() > 0) chk({tag, "_grant_first"}, 64'(grant_log[0]), 64'(first));
    if (second >= 0 && grant_log.size() > 1) chk({tag, "_grant_second"}, 64'(grant_log[1]), 64'(second));
    grant_log.delete();
  endtask

  initial begin
    int s0;
    reset = 1'b1;
    bus.req0 = 1'b0; bus.a0 = '0; bus.b0 = '0;
    bus.req1 = 1'b0; bus.a1 = '0; bus.b1 = '0;
    tick(3);
    chk_zero("reset_outputs");
    reset = 1'b0;
    tick();

    // Single request from client 0.
    s0 = n_start;
    serve("t1", 1'b1, 8'd100, 8'd7, 16'h000E, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    chk("t1_ack_latency", 64'(ack_cyc[0] - drive_cyc), 64'd1);
    chk("t1_start_count", 64'(n_start - s0), 64'd1);
    chk("t1_rv_after_done", 64'(rv_cyc[0] - done_cyc), 64'd2);
    chk_grants("t1", 0, -1);

    // Single request from client 1 with negative dividend.
    serve("t2", 1'b0, '0, '0, '0, 1'b0, 1'b1, 8'h9C, 8'd7, 16'hFFF2, 1'b0);
    chk_grants("t2", 1, -1);

    // Tie straight after reset: client 0 first.
    do_reset();
    serve("t3", 1'b1, 8'd20, 8'd3, 16'h0006, 1'b0, 1'b1, 8'hF7, 8'd2, 16'hFFFC, 1'b0);
    chk_grants("t3", 0, 1);

    // Client 0 alone, then a tie goes to client 1; extreme operands.
    serve("t4", 1'b1, 8'h80, 8'h01, 16'hFF80, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    chk_grants("t4", 0, -1);
    serve("t5", 1'b1, 8'h7F, 8'hFF, 16'hFF81, 1'b0, 1'b1, 8'hF9, 8'hFE, 16'h0003, 1'b0);
    chk_grants("t5", 1, 0);

    // Spurious done while idle.
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    tick(2);
    chk("spur_idle_quiet", {59'd0, bus.res_valid0, bus.res_valid1, bus.div_start, bus.ack0, bus.ack1}, 64'd0);

    // Spurious done during ISSUE must not be captured.
    begin
      exp_t e;
      bit   ok;
      e.res = 16'h0009; e.dz = 1'b0; q0.push_back(e);
      bus.a0 = 8'd45; bus.b0 = 8'd5; bus.req0 = 1'b1;
      tick();
      chk("spur_issue_ack0", 64'(bus.ack0), 64'd1);
      bus.req0 = 1'b0;
      spur_done = 1'b1;
      tick();
      spur_done = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (q0.size() == 0) begin ok = 1'b1; break; end
      end
      chk("spur_issue_complete", 64'(ok), 64'd1);
      tick(2);
      grant_log.delete();
    end

    // Reset while the divider is busy: result is dropped.
    bus.a0 = 8'd77; bus.b0 = 8'd4; bus.req0 = 1'b1;
    tick();
    chk("midrst_ack0", 64'(bus.ack0), 64'd1);
    bus.req0 = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk_zero("midrst_outputs");
    tick();
    reset = 1'b0;
    tick(6);
    chk("midrst_quiet", {62'd0, bus.res_valid0, bus.res_valid1}, 64'd0);
    grant_log.delete();
    serve("t6", 1'b1, 8'd9, 8'd3, 16'h0003, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    chk_grants("t6", 0, -1);

    // Divide by zero.
    s0 = n_start;
`ifdef DIV_ZERO_BYPASS_EN
    serve("t7", 1'b1, 8'd50, 8'd0, 16'h0000, 1'b1, 1'b0, '0, '0, '0, 1'b0);
    chk("t7_start_count", 64'(n_start - s0), 64'd0);
    chk("t7_rv_after_ack", 64'(rv_cyc[0] - ack_cyc[0]), 64'd1);
`else
    serve("t7", 1'b1, 8'd50, 8'd0, 16'h0000, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    chk("t7_start_count", 64'(n_start - s0), 64'd1);
`endif
    chk("t7_div_b_latched", 64'(bus.div_b), 64'd0);
    chk("t7_div_a_latched", 64'(bus.div_a), 64'd50);
    chk_grants("t7", 0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
